shift_reg_mm_multi: RTL and testbench
=====================================

// Module: shift_reg_mm_multi
// PURPOSE
//  Multi-channel Avalon-MM serial shift-register peripheral for the QKD datapath; parametrised successor to the single-channel shift_reg_mm.
//  NUM_CH independent channels. Each channel is loaded over MM and shifts DATA_W bits (or a programmed length) out and in serially at clk/CLK_DIV.
//  Each channel signals completion on an active-low one-cycle writeresponsevalid_n pulse, exported as a conduit from soc_system.
// PARAMETERS
//  NUM_CH   2   number of channels, 1..16
//  DATA_W   32  shift register width, 1..32
//  CLK_DIV  4   clocks per shift step, >=1
//  ADDR_W   $clog2(NUM_CH)+2  derived; do not override
// PORTS
//  clk_clk                  in   1        system clock
//  reset_reset_n            in   1        asynchronous active-low reset
//  avs_address              in   ADDR_W   {ch, reg[1:0]}
//  avs_write                in   1        write strobe
//  avs_writedata            in   32       write data
//  avs_read                 in   1        read strobe
//  avs_readdata             out  32       read data, fixed latency 1, no waitrequest
//  ser_in                   in   NUM_CH   serial input per channel
//  ser_out                  out  NUM_CH   serial output per channel
//  writeresponsevalid_n     out  NUM_CH   active-low 1-cycle done pulse per channel
// BEHAVIOUR
//  Reset: one clock (clk_clk); reset is asynchronous, active-low (reset_reset_n). Reset clears all sregs, counters, CTRL and STATUS.
//   Reset values: avs_readdata=0, ser_out=0, writeresponsevalid_n=all 1s.
//  Regs per channel:
//   0 DATA: write loads sreg, ignored if busy; read returns live sreg, zero-extended.
//   1 CTRL: [0] START, self-clearing; [1] DIR (0=MSB-first, 1=LSB-first); [13:8] LEN.
//   2 STATUS: [0] BUSY, [1] DONE (W1C), [2] ERR (W1C, set by DATA/START write while busy).
//   3 ID: {8'h0, NUM_CH[7:0], DATA_W[7:0], 8'h5A}.
//  LEN=0 or LEN>DATA_W -> effective length DATA_W.
//  START write at edge T with BUSY=0: BUSY=1 visible at T+1, DONE cleared, divider cleared, bit counter=length.
//   START write while BUSY=1 is ignored and sets ERR.
//  Shift on divider==CLK_DIV-1 (first at T+CLK_DIV):
//   DIR=0: sreg<={sreg[DATA_W-2:0],ser_in}; DIR=1: sreg<={ser_in,sreg[DATA_W-1:1]}.
//   ser_out is registered: shows the bit about to shift (MSB or LSB), held while idle.
//  Last shift at T+len*CLK_DIV: BUSY=0 and DONE=1 on the same edge; writeresponsevalid_n[ch]=0 for exactly the next cycle.
//  Simultaneous W1C of DONE and completion in the same cycle: completion wins, DONE=1.
//  DIR and LEN writes while busy take effect at the next START only (latched at START).
//  Read of unimplemented channel index (>=NUM_CH) returns 0; writes to it are dropped.
//  Reset mid-shift: channel idles at once; no writeresponsevalid_n pulse.
// CONFIGURATION
//  SHIFT_REG_MM_IRQ_EN defined:
//   adds port irq out 1 = |(DONE & IE) over channels; CTRL[2] IE, reset 0.
//   irq deasserts the cycle after the last DONE is W1C-cleared.
//  Undefined: no irq port; CTRL[2] reads 0 and writes are ignored.
// STRUCTURE
//  Package shift_reg_mm_pkg holds:
//   register offsets REG_DATA/REG_CTRL/REG_STATUS/REG_ID
//   CTRL/STATUS bit indices, ID magic 8'h5A, LEN field width 6
//  Sub-module shift_reg_mm_chan, one per channel via generate, holds the sreg, divider, bit counter and flags.
//  Top holds address decode, readdata mux and irq reduction.
// TESTING
//  NUM_CH=2,DATA_W=8,CLK_DIV=4; ch0 DATA=8'hA5, CTRL=START,DIR=0,LEN=0, ser_in=1
//   -> ser_out 1,0,1,0,0,1,0,1; DATA reads 8'hFF; pulse low 1 cycle at T+33.
//  ch1 DATA=8'h01, DIR=1, LEN=3, ser_in=0 -> ser_out 1,0,0; DATA reads 8'h00; BUSY=0 after 12 clocks; ch0 untouched.
//  Busy ch0, write DATA=8'h3C -> sreg unchanged, ERR=1; W1C ERR -> ERR=0.
//  START ch0 then assert reset_reset_n=0 at step 3 -> all outputs at reset values, no pulse, STATUS=0.
//  W1C DONE in the completion cycle -> DONE=1.
//  IRQ_EN on: IE=1, complete -> irq=1; W1C DONE -> irq=0 the next cycle.
//  Read ID -> 32'h0002085A.

Source files
------------

// File: rtl/shift_reg_mm_pkg.sv
// Shared definitions for the multi-channel Avalon-MM shift-register peripheral:
// register map, CTRL/STATUS bit positions, ID magic and the length-clamp helper.
package shift_reg_mm_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_CTRL   = 2'd1,
    REG_STATUS = 2'd2,
    REG_ID     = 2'd3
  } reg_e;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_DIR_BIT    = 1;
  localparam int CTRL_IE_BIT     = 2;
  localparam int CTRL_LEN_LSB    = 8;
  localparam int LEN_W           = 6;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int STATUS_ERR_BIT  = 2;

  localparam logic [7:0] ID_MAGIC = 8'h5A;

  // A zero or oversized LEN means "shift the whole register".
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len, input int data_w);
    if ((len == 6'd0) || (int'(len) > data_w)) begin
      eff_len = LEN_W'(data_w);
    end else begin
      eff_len = len;
    end
  endfunction

endpackage

// File: rtl/shift_reg_mm_chan.sv
// One shift-register channel: shift register, clock divider, bit counter,
// BUSY/DONE/ERR flags, registered serial output and the active-low done pulse.
// Optional feature: SHIFT_REG_MM_IRQ_EN adds the CTRL interrupt-enable bit.
module shift_reg_mm_chan
  import shift_reg_mm_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] wdata,
  input  logic        ser_in,
  output logic        ser_out,
  output logic        resp_n,
  output logic        irq_req,
  output logic [31:0] rdata
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DATA_W-1:0] sreg_r, sreg_s;
  logic [DIV_W-1:0]  div_r, div_s;
  logic [LEN_W-1:0]  cnt_r, cnt_s;
  logic [LEN_W-1:0]  len_cfg_r, len_cfg_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              err_r, err_s;
  logic              dir_act_r, dir_act_s;
  logic              dir_cfg_r, dir_cfg_s;
  logic              ie_r, ie_s;
  logic              ser_out_r, ser_out_s;
  logic              resp_n_r, resp_n_s;
  logic              irq_r, irq_s;

  // Shift candidates carry one extra bit so DATA_W=1 needs no special case.
  logic [DATA_W:0]   shl_s;
  logic [DATA_W:0]   shr_s;
  assign shl_s = {sreg_r, ser_in};
  assign shr_s = {ser_in, sreg_r};

  // Upper write-data bits are only meaningful for some registers.
  logic unused_wdata_s;
  assign unused_wdata_s = ^wdata;

  // Next-state: MM writes first, then the shift engine so completion overrides a W1C of DONE.
  always_comb begin
    sreg_s    = sreg_r;
    div_s     = div_r;
    cnt_s     = cnt_r;
    len_cfg_s = len_cfg_r;
    busy_s    = busy_r;
    done_s    = done_r;
    err_s     = err_r;
    dir_act_s = dir_act_r;
    dir_cfg_s = dir_cfg_r;
    ie_s      = ie_r;
    ser_out_s = ser_out_r;
    resp_n_s  = 1'b1;

    if (wr_en) begin
      case (reg_e'(reg_sel))
        REG_DATA: begin
          if (busy_r) begin
            err_s = 1'b1;
          end else begin
            sreg_s = wdata[DATA_W-1:0];
          end
        end
        REG_CTRL: begin
          dir_cfg_s = wdata[CTRL_DIR_BIT];
          len_cfg_s = wdata[CTRL_LEN_LSB +: LEN_W];
`ifdef SHIFT_REG_MM_IRQ_EN
          ie_s      = wdata[CTRL_IE_BIT];
`else
          ie_s      = 1'b0;
`endif
          if (wdata[CTRL_START_BIT]) begin
            if (busy_r) begin
              err_s = 1'b1;
            end else begin
              busy_s    = 1'b1;
              done_s    = 1'b0;
              div_s     = '0;
              cnt_s     = eff_len(wdata[CTRL_LEN_LSB +: LEN_W], DATA_W);
              dir_act_s = wdata[CTRL_DIR_BIT];
              ser_out_s = wdata[CTRL_DIR_BIT] ? sreg_r[0] : sreg_r[DATA_W-1];
            end
          end else begin
            busy_s = busy_r;
          end
        end
        REG_STATUS: begin
          if (wdata[STATUS_DONE_BIT]) begin
            done_s = 1'b0;
          end else begin
            done_s = done_r;
          end
          if (wdata[STATUS_ERR_BIT]) begin
            err_s = 1'b0;
          end else begin
            err_s = err_r;
          end
        end
        default: begin
          sreg_s = sreg_r;
        end
      endcase
    end else begin
      sreg_s = sreg_r;
    end

    if (busy_r) begin
      if (div_r == DIV_LAST) begin
        div_s     = '0;
        sreg_s    = dir_act_r ? shr_s[DATA_W:1] : shl_s[DATA_W-1:0];
        ser_out_s = dir_act_r ? sreg_s[0] : sreg_s[DATA_W-1];
        cnt_s     = cnt_r - LEN_W'(1);
        if (cnt_r == LEN_W'(1)) begin
          busy_s   = 1'b0;
          done_s   = 1'b1;
          resp_n_s = 1'b0;
        end else begin
          busy_s   = 1'b1;
        end
      end else begin
        div_s = div_r + DIV_W'(1);
      end
    end else begin
      div_s = div_s;
    end

    irq_s = done_s & ie_s;
  end

  // State registers; reset idles the channel immediately and suppresses any pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_r    <= '0;
      div_r     <= '0;
      cnt_r     <= '0;
      len_cfg_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      dir_act_r <= 1'b0;
      dir_cfg_r <= 1'b0;
      ie_r      <= 1'b0;
      ser_out_r <= 1'b0;
      resp_n_r  <= 1'b1;
      irq_r     <= 1'b0;
    end else begin
      sreg_r    <= sreg_s;
      div_r     <= div_s;
      cnt_r     <= cnt_s;
      len_cfg_r <= len_cfg_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      err_r     <= err_s;
      dir_act_r <= dir_act_s;
      dir_cfg_r <= dir_cfg_s;
      ie_r      <= ie_s;
      ser_out_r <= ser_out_s;
      resp_n_r  <= resp_n_s;
      irq_r     <= irq_s;
    end
  end

  // Register view for the top-level read mux (ID is supplied by the top).
  always_comb begin
    rdata = 32'h0;
    case (reg_e'(reg_sel))
      REG_DATA: begin
        rdata = 32'(sreg_r);
      end
      REG_CTRL: begin
        rdata[CTRL_DIR_BIT]               = dir_cfg_r;
        rdata[CTRL_IE_BIT]                = ie_r;
        rdata[CTRL_LEN_LSB +: LEN_W]      = len_cfg_r;
      end
      REG_STATUS: begin
        rdata[STATUS_BUSY_BIT] = busy_r;
        rdata[STATUS_DONE_BIT] = done_r;
        rdata[STATUS_ERR_BIT]  = err_r;
      end
      default: begin
        rdata = 32'h0;
      end
    endcase
  end

  assign ser_out = ser_out_r;
  assign resp_n  = resp_n_r;
  assign irq_req = irq_r;

endmodule

// File: rtl/shift_reg_mm_multi.sv
// Multi-channel Avalon-MM serial shift-register peripheral. Address is
// {channel, reg[1:0]}; read data has fixed latency 1 and no waitrequest.
// Optional feature: SHIFT_REG_MM_IRQ_EN adds the irq output (OR of DONE & IE).
module shift_reg_mm_multi
  import shift_reg_mm_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = $clog2(NUM_CH) + 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  input  logic [NUM_CH-1:0] ser_in,
  output logic [NUM_CH-1:0] ser_out,
  output logic [NUM_CH-1:0] writeresponsevalid_n
`ifdef SHIFT_REG_MM_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [31:0] ID_VALUE = {8'h00, 8'(NUM_CH), 8'(DATA_W), ID_MAGIC};

  logic [ADDR_W-1:0] ch_sel_s;
  logic [1:0]        reg_sel_s;
  logic              ch_valid_s;
  logic [NUM_CH-1:0] ch_wr_s;
  logic [NUM_CH-1:0] irq_req_s;
  logic [31:0]       chan_rdata_s [NUM_CH];
  logic [31:0]       rd_mux_s;

  assign ch_sel_s   = avs_address >> 2;
  assign reg_sel_s  = avs_address[1:0];
  assign ch_valid_s = (ch_sel_s < ADDR_W'(NUM_CH));

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_wr_s[gi] = avs_write & (ch_sel_s == ADDR_W'(gi));

    shift_reg_mm_chan #(
      .DATA_W  (DATA_W),
      .CLK_DIV (CLK_DIV)
    ) u_chan (
      .clk     (clk_clk),
      .rst_n   (reset_reset_n),
      .wr_en   (ch_wr_s[gi]),
      .reg_sel (reg_sel_s),
      .wdata   (avs_writedata),
      .ser_in  (ser_in[gi]),
      .ser_out (ser_out[gi]),
      .resp_n  (writeresponsevalid_n[gi]),
      .irq_req (irq_req_s[gi]),
      .rdata   (chan_rdata_s[gi])
    );
  end

  // Read mux: selected channel's register, constant ID, zero for absent channels.
  always_comb begin
    rd_mux_s = 32'h0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel_s == ADDR_W'(i)) begin
        rd_mux_s = chan_rdata_s[i];
      end else begin
        rd_mux_s = rd_mux_s;
      end
    end
    if (!ch_valid_s) begin
      rd_mux_s = 32'h0;
    end else if (reg_e'(reg_sel_s) == REG_ID) begin
      rd_mux_s = ID_VALUE;
    end else begin
      rd_mux_s = rd_mux_s;
    end
  end

  // Registered read data, returned one cycle after the read strobe.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= 32'h0;
    end else if (avs_read) begin
      avs_readdata <= rd_mux_s;
    end else begin
      avs_readdata <= 32'h0;
    end
  end

`ifdef SHIFT_REG_MM_IRQ_EN
  assign irq = |irq_req_s;
`else
  logic unused_irq_s;
  assign unused_irq_s = |irq_req_s;
`endif

endmodule

// File: tb/tb_shift_reg_mm_multi.sv
// Self-checking bench for shift_reg_mm_multi (NUM_CH=2, DATA_W=8, CLK_DIV=4).
// Expected values are queued when stimulus is applied and popped as the DUT responds.
module tb_shift_reg_mm_multi;

  localparam int NUM_CH  = 2;
  localparam int DATA_W  = 8;
  localparam int CLK_DIV = 4;
  localparam int ADDR_W  = $clog2(NUM_CH) + 2;

  localparam logic [1:0] R_DATA   = 2'd0;
  localparam logic [1:0] R_CTRL   = 2'd1;
  localparam logic [1:0] R_STATUS = 2'd2;
  localparam logic [1:0] R_ID     = 2'd3;

  logic              clk = 1'b0;
  logic              reset_reset_n;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              avs_read;
  logic [31:0]       avs_readdata;
  logic [NUM_CH-1:0] ser_in;
  logic [NUM_CH-1:0] ser_out;
  logic [NUM_CH-1:0] writeresponsevalid_n;
`ifdef SHIFT_REG_MM_IRQ_EN
  logic              irq;
`endif

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  pulse_cnt [NUM_CH] = '{0, 0};

  shift_reg_mm_multi #(
    .NUM_CH  (NUM_CH),
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk_clk              (clk),
    .reset_reset_n        (reset_reset_n),
    .avs_address          (avs_address),
    .avs_write            (avs_write),
    .avs_writedata        (avs_writedata),
    .avs_read             (avs_read),
    .avs_readdata         (avs_readdata),
    .ser_in               (ser_in),
    .ser_out              (ser_out),
    .writeresponsevalid_n (writeresponsevalid_n)
`ifdef SHIFT_REG_MM_IRQ_EN
    ,
    .irq                  (irq)
`endif
  );

  always #5 clk = ~clk;

  // Cycle counter used to aim writes at an exact edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Count low cycles of each done pulse.
  always @(negedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (writeresponsevalid_n[i] === 1'b0) pulse_cnt[i] = pulse_cnt[i] + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    sb_q.push_back('{tag, val});
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    sb_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, obs, e.val);
    end else begin
      check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
    end
  endtask

  function automatic logic [ADDR_W-1:0] mk_addr(input int ch, input logic [1:0] r);
    return ADDR_W'((ch << 2) | int'(r));
  endfunction

  task automatic mm_write(input int ch, input logic [1:0] r, input logic [31:0] d);
    @(negedge clk);
    avs_address   = mk_addr(ch, r);
    avs_writedata = d;
    avs_write     = 1'b1;
    @(posedge clk);
    #1;
    avs_write     = 1'b0;
  endtask

  task automatic mm_read_chk(input int ch, input logic [1:0] r, input logic [31:0] exp, input string tag);
    sb_push(tag, exp);
    @(negedge clk);
    avs_address = mk_addr(ch, r);
    avs_read    = 1'b1;
    @(posedge clk);
    #1;
    avs_read    = 1'b0;
    @(negedge clk);
    pop_chk(avs_readdata);
  endtask

  // Watch the serial output for n_bits steps, then the done pulse around the last edge.
  task automatic watch_shift(input int ch, input int n_bits, input string tag);
    for (int k = 0; k < n_bits; k++) begin
      @(negedge clk);
      pop_chk(32'(ser_out[ch]));
      repeat (CLK_DIV - 1) @(negedge clk);
    end
    sb_push({tag, "_resp_pre"},   32'd1);
    sb_push({tag, "_resp_pulse"}, 32'd0);
    sb_push({tag, "_resp_post"},  32'd1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      pop_chk(32'(writeresponsevalid_n[ch]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    int t0;
    int n;
    int pc0;

    avs_address   = '0;
    avs_write     = 1'b0;
    avs_writedata = 32'h0;
    avs_read      = 1'b0;
    ser_in        = '0;
    reset_reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_readdata", avs_readdata, 32'h0);
    check_val("rst_ser_out", 32'(ser_out), 32'h0);
    check_val("rst_resp_n", 32'(writeresponsevalid_n), 32'h3);
    reset_reset_n = 1'b1;

    mm_read_chk(0, R_ID, 32'h0002085A, "id_ch0");
    mm_read_chk(1, R_ID, 32'h0002085A, "id_ch1");

    // ch0: 0xA5 MSB-first, ser_in=1
    ser_in[0] = 1'b1;
    mm_write(0, R_DATA, 32'hA5);
    mm_read_chk(0, R_DATA, 32'hA5, "ch0_data_load");
    v = 8'hA5;
    for (int k = 7; k >= 0; k--) sb_push("ch0_ser_out", 32'(v[k]));
    mm_write(0, R_CTRL, 32'h1);
    watch_shift(0, 8, "ch0");
    for (int k = 0; k < 8; k++) v = {v[6:0], 1'b1};
    mm_read_chk(0, R_DATA, 32'(v), "ch0_data_after");
    mm_read_chk(0, R_STATUS, 32'h2, "ch0_status_done");

    // ch1: 0x01 LSB-first, LEN=3, ser_in=0
    ser_in[1] = 1'b0;
    mm_write(1, R_DATA, 32'h01);
    v = 8'h01;
    for (int k = 0; k < 3; k++) sb_push("ch1_ser_out", 32'(v[k]));
    mm_write(1, R_CTRL, 32'h0303);
    watch_shift(1, 3, "ch1");
    for (int k = 0; k < 3; k++) v = {1'b0, v[7:1]};
    mm_read_chk(1, R_DATA, 32'(v), "ch1_data_after");
    mm_read_chk(1, R_STATUS, 32'h2, "ch1_status_done");
    mm_read_chk(1, R_CTRL, 32'h0302, "ch1_ctrl_readback");
    mm_read_chk(0, R_DATA, 32'hFF, "ch0_untouched_data");
    mm_read_chk(0, R_STATUS, 32'h2, "ch0_untouched_status");
    check_val("ch0_ser_out_held", 32'(ser_out[0]), 32'd1);
    check_val("ch0_pulse_count", 32'(pulse_cnt[0]), 32'd1);
    check_val("ch1_pulse_count", 32'(pulse_cnt[1]), 32'd1);

    // ch0 busy: DATA/START writes flag ERR, W1C DONE loses to completion
    mm_write(0, R_CTRL, 32'h1);
    t0 = cyc;
    mm_write(0, R_DATA, 32'h3C);
    mm_read_chk(0, R_DATA, 32'hFF, "ch0_data_busy_ignored");
    mm_read_chk(0, R_STATUS, 32'h5, "ch0_err_data_busy");
    mm_write(0, R_STATUS, 32'h4);
    mm_read_chk(0, R_STATUS, 32'h1, "ch0_err_w1c");
    mm_write(0, R_CTRL, 32'h1);
    mm_read_chk(0, R_STATUS, 32'h5, "ch0_err_start_busy");
    mm_write(0, R_STATUS, 32'h4);
    while (cyc < t0 + 8 * CLK_DIV - 1) begin
      @(posedge clk);
      #1;
    end
    mm_write(0, R_STATUS, 32'h2);
    mm_read_chk(0, R_STATUS, 32'h2, "ch0_done_wins_w1c");

    // reset mid-shift
    ser_in[0] = 1'b0;
    mm_write(0, R_DATA, 32'hA5);
    mm_write(0, R_CTRL, 32'h1);
    pc0 = pulse_cnt[0];
    repeat (2 * CLK_DIV + 3) @(negedge clk);
    v = 8'hA5;
    check_val("ch0_ser_out_step3", 32'(v[5]), 32'(ser_out[0]));
    reset_reset_n = 1'b0;
    #1;
    check_val("midrst_ser_out", 32'(ser_out), 32'h0);
    check_val("midrst_resp_n", 32'(writeresponsevalid_n), 32'h3);
    check_val("midrst_readdata", avs_readdata, 32'h0);
    @(negedge clk);
    reset_reset_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check_val("midrst_no_pulse", 32'(pulse_cnt[0]), 32'(pc0));
    check_val("midrst_ser_out_idle", 32'(ser_out), 32'h0);
    mm_read_chk(0, R_STATUS, 32'h0, "midrst_status_ch0");
    mm_read_chk(0, R_DATA, 32'h0, "midrst_data_ch0");
    mm_read_chk(1, R_STATUS, 32'h0, "midrst_status_ch1");

    // LEN above DATA_W clamps to DATA_W
    mm_write(1, R_DATA, 32'h81);
    mm_write(1, R_CTRL, 32'h2801);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((writeresponsevalid_n[1] !== 1'b0) && (n < 100));
    check_val("ch1_len_clamp_cycles", 32'(n), 32'(DATA_W * CLK_DIV + 1));

    mm_write(1, R_STATUS, 32'h6);
    mm_write(1, R_CTRL, 32'h0506);
`ifdef SHIFT_REG_MM_IRQ_EN
    mm_read_chk(1, R_CTRL, 32'h0506, "ch1_ctrl_ie");
    check_val("irq_idle", 32'(irq), 32'h0);
    mm_write(0, R_CTRL, 32'h5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((writeresponsevalid_n[0] !== 1'b0) && (n < 100));
    check_val("irq_wait_cycles", 32'(n), 32'(DATA_W * CLK_DIV + 1));
    check_val("irq_raised", 32'(irq), 32'h1);
    mm_write(0, R_STATUS, 32'h2);
    check_val("irq_cleared", 32'(irq), 32'h0);
`else
    mm_read_chk(1, R_CTRL, 32'h0502, "ch1_ctrl_no_ie");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
